// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the microsequencer and its datapath: opcodes,
// register indices, bus/ALU encodings, sequencer states and the control word.
package ctrl_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREG   = 5;
  localparam int unsigned BUS_W  = 3;
  localparam int unsigned ALU_W  = 2;

  // Register indices into the Wen/INC/CLR vectors
  localparam int unsigned REG_PC = 0;
  localparam int unsigned REG_AR = 1;
  localparam int unsigned REG_IR = 2;
  localparam int unsigned REG_AC = 3;
  localparam int unsigned REG_R  = 4;

  // One-hot strobe masks, one per register
  localparam logic [NREG-1:0] M_PC = NREG'(1 << REG_PC);
  localparam logic [NREG-1:0] M_AR = NREG'(1 << REG_AR);
  localparam logic [NREG-1:0] M_IR = NREG'(1 << REG_IR);
  localparam logic [NREG-1:0] M_AC = NREG'(1 << REG_AC);
  localparam logic [NREG-1:0] M_R  = NREG'(1 << REG_R);

  // Shared-bus source encodings
  localparam logic [BUS_W-1:0] BUS_PC  = 3'd0;
  localparam logic [BUS_W-1:0] BUS_AR  = 3'd1;
  localparam logic [BUS_W-1:0] BUS_IR  = 3'd2;
  localparam logic [BUS_W-1:0] BUS_AC  = 3'd3;
  localparam logic [BUS_W-1:0] BUS_R   = 3'd4;
  localparam logic [BUS_W-1:0] BUS_MEM = 3'd5;

  // ALU operations feeding AC
  localparam logic [ALU_W-1:0] ALU_PASS = 2'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 2'd1;

  // Instruction set
  localparam logic [DATA_W-1:0] OP_NOP  = 8'h00;
  localparam logic [DATA_W-1:0] OP_MVAC = 8'h01;
  localparam logic [DATA_W-1:0] OP_MVR  = 8'h02;
  localparam logic [DATA_W-1:0] OP_ADD  = 8'h03;
  localparam logic [DATA_W-1:0] OP_INAC = 8'h04;
  localparam logic [DATA_W-1:0] OP_CLAC = 8'h05;
  localparam logic [DATA_W-1:0] OP_LDI  = 8'h06;
  localparam logic [DATA_W-1:0] OP_JMP  = 8'h07;
  localparam logic [DATA_W-1:0] OP_JPNZ = 8'h08;
  localparam logic [DATA_W-1:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FETCH1,
    ST_FETCH2,
    ST_DECODE,
    ST_EX0,
    ST_EX1,
    ST_HALT
  } state_e;

  // Control word driven onto the datapath each cycle
  typedef struct packed {
    logic [NREG-1:0]  wen;
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  clr;
    logic [BUS_W-1:0] bus_sel;
    logic [ALU_W-1:0] alu_op;
    logic             mem_rd;
  } ctrl_t;

  // Opcodes the sequencer recognises
  function automatic logic is_known_op(input logic [DATA_W-1:0] op);
    return (op <= OP_JPNZ) || (op == OP_HALT);
  endfunction

  // Instructions that need a second, memory-reading execute step
  function automatic logic needs_ex1(input logic [DATA_W-1:0] op, input logic z);
    return (op == OP_LDI) || (op == OP_JMP) || ((op == OP_JPNZ) && !z);
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational decode of sequencer state + latched opcode into the control word.
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
(
  input  state_e            state,
  input  logic [DATA_W-1:0] op_q,
  input  logic              z_q,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] ir_in,
  output ctrl_t             ctrl_c,
  output logic              busy_c,
  output logic              halted_c,
  output logic              illegal_c
);

  // Strobes per state; memory-completion strobes gated by mem_rdy
  always_comb begin
    ctrl_c    = '0;
    busy_c    = (state != ST_IDLE) && (state != ST_HALT);
    halted_c  = (state == ST_HALT);
    illegal_c = 1'b0;
    case (state)
      ST_INIT: ctrl_c.clr = '1;
      ST_FETCH1: begin
        ctrl_c.bus_sel = BUS_PC;
        ctrl_c.wen     = M_AR;
      end
      ST_FETCH2: begin
        ctrl_c.mem_rd  = 1'b1;
        ctrl_c.bus_sel = BUS_MEM;
        if (mem_rdy) begin
          ctrl_c.wen = M_IR;
          ctrl_c.inc = M_PC;
        end
      end
      ST_DECODE: illegal_c = !is_known_op(ir_in);
      ST_EX0: begin
        case (op_q)
          OP_MVAC: begin
            ctrl_c.bus_sel = BUS_AC;
            ctrl_c.wen     = M_R;
          end
          OP_MVR: begin
            ctrl_c.bus_sel = BUS_R;
            ctrl_c.alu_op  = ALU_PASS;
            ctrl_c.wen     = M_AC;
          end
          OP_ADD: begin
            ctrl_c.bus_sel = BUS_R;
            ctrl_c.alu_op  = ALU_ADD;
            ctrl_c.wen     = M_AC;
          end
          OP_INAC: ctrl_c.inc = M_AC;
          OP_CLAC: ctrl_c.clr = M_AC;
          OP_LDI, OP_JMP: begin
            ctrl_c.bus_sel = BUS_PC;
            ctrl_c.wen     = M_AR;
          end
          OP_JPNZ: begin
            if (z_q) begin
              ctrl_c.inc = M_PC;
            end else begin
              ctrl_c.bus_sel = BUS_PC;
              ctrl_c.wen     = M_AR;
            end
          end
          default: ;
        endcase
      end
      ST_EX1: begin
        ctrl_c.mem_rd  = 1'b1;
        ctrl_c.bus_sel = BUS_MEM;
        if (op_q == OP_LDI) begin
          ctrl_c.alu_op = ALU_PASS;
          if (mem_rdy) begin
            ctrl_c.wen = M_AC;
            ctrl_c.inc = M_PC;
          end
        end else if (mem_rdy) begin
          ctrl_c.wen = M_PC;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch-decode-execute microsequencer for the 8-bit bus datapath.
module ctrl_seq
  import ctrl_seq_pkg::*;
(
  input  logic              Clk,
  input  logic              RST,
  input  logic              Start,
  input  logic [DATA_W-1:0] IR_in,
  input  logic              Zflag,
  input  logic              MemRdy,
  output logic [NREG-1:0]   Wen,
  output logic [NREG-1:0]   INC,
  output logic [NREG-1:0]   CLR,
  output logic [BUS_W-1:0]  BusSel,
  output logic [ALU_W-1:0]  AluOp,
  output logic              MemRd,
  output logic              Busy,
  output logic              Halted,
  output logic              IllegalOp
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_q;
  logic              z_q;
  ctrl_t             ctrl_c;

  // State register; reset returns to IDLE so all strobes drop at once
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Opcode and zero flag captured during DECODE for the execute steps
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      op_q <= '0;
      z_q  <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      op_q <= IR_in;
      z_q  <= Zflag;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Start) state_d = ST_INIT;
      ST_INIT:   state_d = ST_FETCH1;
      ST_FETCH1: state_d = ST_FETCH2;
      ST_FETCH2: if (MemRdy) state_d = ST_DECODE;
      ST_DECODE: begin
        if (IR_in == OP_HALT)                             state_d = ST_HALT;
        else if ((IR_in == OP_NOP) || !is_known_op(IR_in)) state_d = ST_FETCH1;
        else                                              state_d = ST_EX0;
      end
      ST_EX0:    state_d = needs_ex1(op_q, z_q) ? ST_EX1 : ST_FETCH1;
      ST_EX1:    if (MemRdy) state_d = ST_FETCH1;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  ctrl_seq_decode u_decode (
    .state     (state_q),
    .op_q      (op_q),
    .z_q       (z_q),
    .mem_rdy   (MemRdy),
    .ir_in     (IR_in),
    .ctrl_c    (ctrl_c),
    .busy_c    (Busy),
    .halted_c  (Halted),
    .illegal_c (IllegalOp)
  );

  assign Wen    = ctrl_c.wen;
  assign INC    = ctrl_c.inc;
  assign CLR    = ctrl_c.clr;
  assign BusSel = ctrl_c.bus_sel;
  assign AluOp  = ctrl_c.alu_op;
  assign MemRd  = ctrl_c.mem_rd;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed table, reset/halt sequences and
// a random program checked against a per-instruction cycle model.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  logic       Clk, RST, Start, Zflag, MemRdy;
  logic [7:0] IR_in;
  logic [4:0] Wen, INC, CLR;
  logic [2:0] BusSel;
  logic [1:0] AluOp;
  logic       MemRd, Busy, Halted, IllegalOp;

  ctrl_seq dut (
    .Clk(Clk), .RST(RST), .Start(Start), .IR_in(IR_in), .Zflag(Zflag),
    .MemRdy(MemRdy), .Wen(Wen), .INC(INC), .CLR(CLR), .BusSel(BusSel),
    .AluOp(AluOp), .MemRd(MemRd), .Busy(Busy), .Halted(Halted),
    .IllegalOp(IllegalOp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] wen, inc, clr;
    logic [2:0] bus;
    logic [1:0] alu;
    logic       memrd, busy, halted, ill;
  } obs_t;

  typedef struct packed {
    logic       start;
    logic [7:0] ir;
    logic       z, rdy;
    obs_t       exp;
  } cyc_t;

  localparam logic [4:0] N    = 5'b00000;
  localparam logic [4:0] B_PC = 5'b00001;
  localparam logic [4:0] B_AR = 5'b00010;
  localparam logic [4:0] B_IR = 5'b00100;
  localparam logic [4:0] B_AC = 5'b01000;
  localparam logic [4:0] B_R  = 5'b10000;

  int   n_checks = 0;
  int   n_fail   = 0;
  cyc_t q[$];
  cyc_t tbl [27];

  function automatic obs_t o(input logic [4:0] wen, inc, clr, input logic [2:0] bus,
                             input logic [1:0] alu, input logic memrd, busy, halted, ill);
    obs_t r;
    r.wen = wen; r.inc = inc; r.clr = clr; r.bus = bus; r.alu = alu;
    r.memrd = memrd; r.busy = busy; r.halted = halted; r.ill = ill;
    return r;
  endfunction

  function automatic cyc_t cy(input logic start, input logic [7:0] ir,
                              input logic z, rdy, input obs_t e);
    cyc_t c;
    c.start = start; c.ir = ir; c.z = z; c.rdy = rdy; c.exp = e;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rir();
    return 8'($urandom);
  endfunction

  function automatic obs_t cur();
    return o(Wen, INC, CLR, BusSel, AluOp, MemRd, Busy, Halted, IllegalOp);
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("wen=%b inc=%b clr=%b bus=%0d alu=%0d rd=%b busy=%b halt=%b ill=%b",
                     v.wen, v.inc, v.clr, v.bus, v.alu, v.memrd, v.busy, v.halted, v.ill);
  endfunction

  // Common expected cycles
  function automatic obs_t o_zero();   return o(N, N, N, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); endfunction
  function automatic obs_t o_busy();   return o(N, N, N, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); endfunction
  function automatic obs_t o_init();   return o(N, N, 5'b11111, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); endfunction
  function automatic obs_t o_f1();     return o(B_AR, N, N, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); endfunction
  function automatic obs_t o_mwait();  return o(N, N, N, 3'd5, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0); endfunction
  function automatic obs_t o_fdone();  return o(B_IR, B_PC, N, 3'd5, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0); endfunction
  function automatic obs_t o_halt();   return o(N, N, N, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0); endfunction

  // Reference model: expected cycles of one instruction, built from the ISA table
  function automatic void gen_fetch(input int waits);
    q.push_back(cy(rb(), rir(), rb(), rb(), o_f1()));
    for (int i = 0; i < waits; i++) q.push_back(cy(rb(), rir(), rb(), 1'b0, o_mwait()));
    q.push_back(cy(rb(), rir(), rb(), 1'b1, o_fdone()));
  endfunction

  function automatic void gen_mem_step(input int waits, input obs_t done);
    for (int i = 0; i < waits; i++) q.push_back(cy(rb(), rir(), rb(), 1'b0, o_mwait()));
    q.push_back(cy(rb(), rir(), rb(), 1'b1, done));
  endfunction

  function automatic void gen_instr(input logic [7:0] op, input logic z, input int fw, ew);
    logic known;
    known = (op <= 8'h08) || (op == 8'hFF);
    gen_fetch(fw);
    q.push_back(cy(rb(), op, z, rb(), o(N, N, N, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, !known)));
    case (op)
      8'h01: q.push_back(cy(rb(), rir(), rb(), rb(), o(B_R, N, N, 3'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
      8'h02: q.push_back(cy(rb(), rir(), rb(), rb(), o(B_AC, N, N, 3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
      8'h03: q.push_back(cy(rb(), rir(), rb(), rb(), o(B_AC, N, N, 3'd4, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0)));
      8'h04: q.push_back(cy(rb(), rir(), rb(), rb(), o(N, B_AC, N, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
      8'h05: q.push_back(cy(rb(), rir(), rb(), rb(), o(N, N, B_AC, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
      8'h06: begin
        q.push_back(cy(rb(), rir(), rb(), rb(), o_f1()));
        gen_mem_step(ew, o(B_AC, B_PC, N, 3'd5, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      end
      8'h07, 8'h08: begin
        if (op == 8'h08 && z) begin
          q.push_back(cy(rb(), rir(), rb(), rb(), o(N, B_PC, N, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        end else begin
          q.push_back(cy(rb(), rir(), rb(), rb(), o_f1()));
          gen_mem_step(ew, o(B_PC, N, N, 3'd5, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check(input obs_t act, input obs_t exp, input string tag, input int idx);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got {%s} want {%s}", tag, idx, fmt(act), fmt(exp));
    end
  endtask

  task automatic step(input cyc_t c, input string tag, input int idx);
    @(negedge Clk);
    Start = c.start; IR_in = c.ir; Zflag = c.z; MemRdy = c.rdy;
    #1;
    check(cur(), c.exp, tag, idx);
  endtask

  task automatic run_trace(input string tag);
    for (int i = 0; i < q.size(); i++) step(q[i], tag, i);
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    RST = 1'b0; Start = 1'b1; MemRdy = 1'b1; IR_in = 8'hFF; Zflag = 1'b1;
    #1;
    check(cur(), o_zero(), "reset", 0);
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    #1;
    check(cur(), o_zero(), "reset_hold", 0);
    @(negedge Clk);
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0; Start = 1'b0; MemRdy = 1'b0; IR_in = 8'h00; Zflag = 1'b0;

    // Directed table: reset/start, fetch wait, ADD, JPNZ both ways, illegal op
    tbl[0]  = cy(1'b0, 8'h00, 1'b0, 1'b0, o_zero());
    tbl[1]  = cy(1'b1, 8'h00, 1'b0, 1'b0, o_zero());
    tbl[2]  = cy(1'b0, 8'h00, 1'b0, 1'b0, o_init());
    tbl[3]  = cy(1'b0, 8'h00, 1'b0, 1'b1, o_f1());
    tbl[4]  = cy(1'b0, 8'h00, 1'b0, 1'b0, o_mwait());
    tbl[5]  = cy(1'b0, 8'h00, 1'b0, 1'b0, o_mwait());
    tbl[6]  = cy(1'b0, 8'h00, 1'b0, 1'b0, o_mwait());
    tbl[7]  = cy(1'b0, 8'h00, 1'b0, 1'b1, o_fdone());
    tbl[8]  = cy(1'b0, 8'h03, 1'b0, 1'b1, o_busy());
    tbl[9]  = cy(1'b0, 8'h00, 1'b0, 1'b1, o(B_AC, N, N, 3'd4, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl[10] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_f1());
    tbl[11] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_fdone());
    tbl[12] = cy(1'b0, 8'h03, 1'b0, 1'b1, o_busy());
    tbl[13] = cy(1'b0, 8'h00, 1'b0, 1'b1, o(B_AC, N, N, 3'd4, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl[14] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_f1());
    tbl[15] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_fdone());
    tbl[16] = cy(1'b0, 8'h08, 1'b1, 1'b1, o_busy());
    tbl[17] = cy(1'b0, 8'h00, 1'b0, 1'b1, o(N, B_PC, N, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl[18] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_f1());
    tbl[19] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_fdone());
    tbl[20] = cy(1'b0, 8'h08, 1'b0, 1'b1, o_busy());
    tbl[21] = cy(1'b0, 8'h00, 1'b1, 1'b1, o_f1());
    tbl[22] = cy(1'b0, 8'h00, 1'b0, 1'b1, o(B_PC, N, N, 3'd5, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl[23] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_f1());
    tbl[24] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_fdone());
    tbl[25] = cy(1'b0, 8'h3C, 1'b0, 1'b1, o(N, N, N, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl[26] = cy(1'b0, 8'h00, 1'b0, 1'b1, o_f1());

    do_reset();
    for (int i = 0; i < 27; i++) step(tbl[i], "table", i);

    // Reset during an LDI operand wait, then restart and halt
    do_reset();
    q.push_back(cy(1'b1, rir(), rb(), rb(), o_zero()));
    q.push_back(cy(rb(), rir(), rb(), rb(), o_init()));
    gen_fetch(1);
    q.push_back(cy(rb(), OP_LDI, rb(), rb(), o_busy()));
    q.push_back(cy(rb(), rir(), rb(), rb(), o_f1()));
    q.push_back(cy(rb(), rir(), rb(), 1'b0, o_mwait()));
    q.push_back(cy(rb(), rir(), rb(), 1'b0, o_mwait()));
    run_trace("ldi_wait");
    @(negedge Clk);
    Start = 1'b0; MemRdy = 1'b0;
    #1;
    check(cur(), o_mwait(), "ex1_hold", 0);
    RST = 1'b0;
    #1;
    check(cur(), o_zero(), "async_rst", 0);
    @(negedge Clk);
    RST = 1'b1;
    q.push_back(cy(1'b0, rir(), rb(), 1'b1, o_zero()));
    q.push_back(cy(1'b0, rir(), rb(), 1'b1, o_zero()));
    q.push_back(cy(1'b1, rir(), rb(), 1'b1, o_zero()));
    q.push_back(cy(rb(), rir(), rb(), rb(), o_init()));
    gen_instr(OP_INAC, 1'b0, 0, 0);
    gen_instr(OP_HALT, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) q.push_back(cy(1'b1, rir(), rb(), rb(), o_halt()));
    run_trace("restart_halt");

    // Random program against the cycle model
    do_reset();
    q.push_back(cy(1'b0, rir(), rb(), rb(), o_zero()));
    q.push_back(cy(1'b1, rir(), rb(), rb(), o_zero()));
    q.push_back(cy(rb(), rir(), rb(), rb(), o_init()));
    for (int n = 0; n < 80; n++) begin
      int unsigned k;
      logic [7:0]  op;
      k  = $urandom_range(0, 10);
      op = (k <= 8) ? 8'(k) : 8'($urandom_range(9, 254));
      gen_instr(op, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    gen_instr(OP_HALT, rb(), 1, 0);
    for (int i = 0; i < 5; i++) q.push_back(cy(rb(), rir(), rb(), rb(), o_halt()));
    run_trace("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
